// File: rtl/retire_sync_ctrl.sv
// Pairs the retirement streams of two cores: per-core observation FIFOs, one paired strobe
// to the checker when both sides hold an entry, plus stall, lag-timeout and overflow supervision.
module retire_sync_ctrl #(
  parameter int DEPTH   = 4,
  parameter int OBS_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ret_1_i,
  input  logic [OBS_W-1:0] obs_1_i,
  input  logic             ret_2_i,
  input  logic [OBS_W-1:0] obs_2_i,
  input  logic             cmp_ready_i,
  output logic             stall_1_o,
  output logic             stall_2_o,
  output logic             cmp_valid_o,
  output logic [OBS_W-1:0] cmp_obs_1_o,
  output logic [OBS_W-1:0] cmp_obs_2_o,
  output logic [1:0]       state_o,
  output logic             timeout_o,
  output logic             overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT_1 = 2'b01,
    ST_WAIT_2 = 2'b10,
    ST_ERROR  = 2'b11
  } state_t;

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             cmp_valid_reg, timeout_reg, overflow_reg;
  logic             in_error, pop, timer_hit, lag_push, in_wait;

  // Lane 0 is core 1, lane 1 is core 2.
  logic [1:0]                  ret_vec, push_vec, drop_vec, full_vec, avail_vec;
  logic [1:0][OBS_W-1:0]       obs_vec, head_vec;
  logic [1:0][CNT_W-1:0]       count_next_vec;

  assign ret_vec  = {ret_2_i, ret_1_i};
  assign obs_vec  = {obs_2_i, obs_1_i};
  assign in_error = (state_reg == ST_ERROR);
  assign in_wait  = (state_reg == ST_WAIT_1) || (state_reg == ST_WAIT_2);
  assign pop      = avail_vec[0] & avail_vec[1] & cmp_ready_i & ~in_error;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [OBS_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic [OBS_W-1:0] head_reg;

      assign full_vec[gi]       = (count_reg == FULL_CNT);
      assign avail_vec[gi]      = (count_reg != '0);
      // A full FIFO still accepts a retire when the head leaves in the same cycle.
      assign push_vec[gi]       = ret_vec[gi] & ~in_error & (~full_vec[gi] | pop);
      assign drop_vec[gi]       = ret_vec[gi] & ~in_error & full_vec[gi] & ~pop;
      assign count_next_vec[gi] = count_reg + CNT_W'(push_vec[gi]) - CNT_W'(pop);
      assign head_vec[gi]       = head_reg;

      always_ff @(posedge clk_i) begin
        if (push_vec[gi]) begin
          mem[wr_ptr_reg] <= obs_vec[gi];
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          head_reg   <= '0;
        end else begin
          count_reg <= count_next_vec[gi];
          if (push_vec[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            head_reg   <= mem[rd_ptr_reg];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    lag_push   = ((state_reg == ST_WAIT_1) & push_vec[0]) |
                 ((state_reg == ST_WAIT_2) & push_vec[1]);
    timer_next = timer_reg;
    if ((state_reg == ST_IDLE) || lag_push) begin
      timer_next = '0;
    end else if (in_wait && (timer_reg != TMR_MAX)) begin
      timer_next = timer_reg + TMR_W'(1);
    end
    timer_hit = in_wait && (timer_next == TMR_MAX);

    state_next = ST_IDLE;
    if (in_error || (|drop_vec) || timer_hit) begin
      state_next = ST_ERROR;
    end else if (count_next_vec[1] > count_next_vec[0]) begin
      state_next = ST_WAIT_1;
    end else if (count_next_vec[0] > count_next_vec[1]) begin
      state_next = ST_WAIT_2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      cmp_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      cmp_valid_reg <= pop;
      timeout_reg   <= timeout_reg | timer_hit;
      overflow_reg  <= overflow_reg | (|drop_vec);
    end
  end

  assign stall_1_o   = full_vec[0] | in_error;
  assign stall_2_o   = full_vec[1] | in_error;
  assign cmp_valid_o = cmp_valid_reg;
  assign cmp_obs_1_o = head_vec[0];
  assign cmp_obs_2_o = head_vec[1];
  assign state_o     = state_reg;
  assign timeout_o   = timeout_reg;
  assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_retire_sync_ctrl.sv
// Randomized and directed bench for retire_sync_ctrl: a queue-based reference model predicts
// pairs into a scoreboard that a separate monitor drains whenever the DUT strobes cmp_valid_o.
module tb_retire_sync_ctrl;
  localparam int DEPTH   = 4;
  localparam int OBS_W   = 32;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             ret_1 = 1'b0, ret_2 = 1'b0, cmp_ready = 1'b0;
  logic [OBS_W-1:0] obs_1 = '0, obs_2 = '0;
  logic             stall_1, stall_2, cmp_valid, timeout, overflow;
  logic [OBS_W-1:0] cmp_obs_1, cmp_obs_2;
  logic [1:0]       state;

  retire_sync_ctrl #(.DEPTH(DEPTH), .OBS_W(OBS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ret_1_i(ret_1), .obs_1_i(obs_1), .ret_2_i(ret_2), .obs_2_i(obs_2),
    .cmp_ready_i(cmp_ready),
    .stall_1_o(stall_1), .stall_2_o(stall_2),
    .cmp_valid_o(cmp_valid), .cmp_obs_1_o(cmp_obs_1), .cmp_obs_2_o(cmp_obs_2),
    .state_o(state), .timeout_o(timeout), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pair_no = 0;

  // Reference model: buffered words per core, mode (0 idle,1 core1 lags,2 core2 lags,3 error).
  logic [OBS_W-1:0]   q1[$], q2[$];
  logic [2*OBS_W-1:0] exp_q[$];
  int                 m_state = 0, m_timer = 0;
  logic               m_to = 1'b0, m_ov = 1'b0, m_valid = 1'b0;
  logic [OBS_W-1:0]   m_last1 = '0, m_last2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r1, input logic [OBS_W-1:0] o1, input logic r2,
                            input logic [OBS_W-1:0] o2, input logic rdy, input logic rstn);
    logic err, pp, a1, a2, d1, d2, hit, waiting;
    if (!rstn) begin
      q1.delete(); q2.delete();
      m_state = 0; m_timer = 0; m_to = 0; m_ov = 0; m_valid = 0; m_last1 = '0; m_last2 = '0;
      return;
    end
    err = (m_state == 3);
    waiting = (m_state == 1) || (m_state == 2);
    pp = !err && q1.size() > 0 && q2.size() > 0 && rdy;
    a1 = r1 && !err && (q1.size() < DEPTH || pp);
    a2 = r2 && !err && (q2.size() < DEPTH || pp);
    d1 = r1 && !err && !a1;
    d2 = r2 && !err && !a2;
    m_valid = pp;
    if (pp) begin
      m_last1 = q1.pop_front();
      m_last2 = q2.pop_front();
      exp_q.push_back({m_last1, m_last2});
    end
    if (a1) q1.push_back(o1);
    if (a2) q2.push_back(o2);
    if (m_state == 0 || (m_state == 1 && a1) || (m_state == 2 && a2)) m_timer = 0;
    else if (waiting) m_timer = (m_timer < TIMEOUT) ? m_timer + 1 : TIMEOUT;
    hit = waiting && (m_timer == TIMEOUT);
    if (d1 || d2) m_ov = 1;
    if (hit) m_to = 1;
    if (err || d1 || d2 || hit) m_state = 3;
    else if (q2.size() > q1.size()) m_state = 1;
    else if (q1.size() > q2.size()) m_state = 2;
    else m_state = 0;
  endtask

  task automatic check_outputs();
    check("stall_1", stall_1, (q1.size() == DEPTH) || (m_state == 3));
    check("stall_2", stall_2, (q2.size() == DEPTH) || (m_state == 3));
    check("state", state, m_state);
    check("timeout", timeout, m_to);
    check("overflow", overflow, m_ov);
    check("cmp_valid", cmp_valid, m_valid);
    if (!m_valid) begin
      check("hold_obs_1", cmp_obs_1, m_last1);
      check("hold_obs_2", cmp_obs_2, m_last2);
    end
  endtask

  // Called at a falling edge: drive, advance the model over the next rising edge, then check.
  task automatic step(input logic r1, input logic [OBS_W-1:0] o1, input logic r2,
                      input logic [OBS_W-1:0] o2, input logic rdy, input logic rstn);
    rst_ni = rstn; ret_1 = r1; obs_1 = o1; ret_2 = r2; obs_2 = o2; cmp_ready = rdy;
    model_step(r1, o1, r2, o2, rdy, rstn);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, rdy, 1'b1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pair.
  initial begin
    logic [2*OBS_W-1:0] exp_pair;
    forever begin
      @(posedge clk);
      #1;
      if (cmp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_pair: got %0h/%0h expected no pair", cmp_obs_1, cmp_obs_2);
        end else begin
          exp_pair = exp_q.pop_front();
          check("pair_obs_1", cmp_obs_1, exp_pair[2*OBS_W-1:OBS_W]);
          check("pair_obs_2", cmp_obs_2, exp_pair[OBS_W-1:0]);
          $display("pair %0d obs_1=%08h obs_2=%08h", pair_no, cmp_obs_1, cmp_obs_2);
          pair_no++;
        end
      end
    end
  end

  initial begin
    int   p1, p2, pr;
    logic r1, r2;
    @(negedge clk);
    step(0, '0, 0, '0, 0, 0);
    step(0, '0, 0, '0, 0, 0);

    // Simultaneous retire, one-cycle latency.
    step(1, 32'hA, 1, 32'hA, 1, 1);
    idle(2, 1);

    // Core 1 fills its FIFO, then core 2 catches up.
    for (int i = 0; i < 4; i++) step(1, 32'h100 + i, 0, '0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 32'h200 + i, 1, 1);
    idle(3, 1);

    // Lag timeout.
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 1, 32'h300, 1, 1);
    idle(TIMEOUT + 5, 1);

    // Overflow on a full FIFO without a pop.
    step(0, '0, 0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h400 + i, 0, '0, 1, 1);
    idle(2, 1);

    // Full FIFO pushing while popping in the same cycle.
    step(0, '0, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h500 + i, 0, '0, 1, 1);
    step(0, '0, 1, 32'h600, 0, 1);
    step(1, 32'h504, 0, '0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 32'h601 + i, 1, 1);
    idle(3, 1);

    // Checker backpressure, then drain.
    for (int i = 0; i < 3; i++) step(1, 32'h700 + i, 1, 32'h800 + i, 0, 1);
    idle(5, 1);

    // Reset with buffered entries.
    for (int i = 0; i < 3; i++) step(1, 32'h900 + i, 0, '0, 1, 1);
    step(0, '0, 0, '0, 1, 0);
    idle(2, 1);

    // Randomized episodes with varying retire and ready rates.
    for (int ep = 0; ep < 6; ep++) begin
      step(0, '0, 0, '0, 0, 0);
      p1 = $urandom_range(20, 95);
      p2 = $urandom_range(20, 95);
      pr = $urandom_range(30, 100);
      for (int c = 0; c < 250; c++) begin
        if (m_state == 3) begin
          step(0, '0, 0, '0, 1, $urandom_range(0, 3) != 0);
          continue;
        end
        r1 = ($urandom_range(0, 99) < p1) &&
             ((q1.size() < DEPTH) || ($urandom_range(0, 99) < 3));
        r2 = ($urandom_range(0, 99) < p2) &&
             ((q2.size() < DEPTH) || ($urandom_range(0, 99) < 3));
        step(r1, $urandom, r2, $urandom, $urandom_range(0, 99) < pr, 1);
      end
    end

    step(0, '0, 0, '0, 0, 0);
    idle(2, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
